ram_reader: RTL and testbench
=============================

RAM_READER -- requirements
Module: ram_reader

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the RAM read data and output data width.
REQ-002 Parameter SKID_DEPTH, default 2, SHALL set the output buffer depth; SHALL be at least 2.
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  single-cycle request to begin a readout.
REQ-006 len  in  12  number of entries to read; range 0..2048; sampled with start.
REQ-007 wr_addr  in  11  writer's current (next-to-write) address; sampled with start.
REQ-008 ram_rd_en  out  1  RAM read strobe.
REQ-009 ram_rd_addr  out  11  RAM read address.
REQ-010 ram_rd_data  in  DATA_W  RAM read data; valid exactly 1 cycle after ram_rd_en.
REQ-011 out_data  out  DATA_W  readout data.
REQ-012 out_valid  out  1  out_data valid.
REQ-013 out_ready  in  1  consumer accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-014 busy  out  1  high from the cycle after an accepted start until done.
REQ-015 done  out  1  one-cycle pulse at readout completion.

Function
REQ-016 The writer fills the RAM downward from 0x7FF, so the newest entry sits at wr_addr+1 mod 2048; readout SHALL be newest-first.
REQ-017 On an accepted start, the block SHALL load the read pointer with (wr_addr+1) mod 2048 and load remaining with len.
REQ-018 Each read SHALL increment the pointer modulo 2048, wrapping 0x7FF to 0x000; each read SHALL decrement remaining by 1.
REQ-019 FSM states SHALL be IDLE, READ and DRAIN.
REQ-020 IDLE: start with len != 0 SHALL go to READ; start with len == 0 SHALL pulse done the next cycle and stay in IDLE; otherwise the block SHALL hold.
REQ-021 READ: ram_rd_en SHALL be asserted when remaining > 0 and (buffer occupancy + reads in flight) < SKID_DEPTH; the block SHALL go to DRAIN in the cycle the last read issues.
REQ-022 DRAIN: when the buffer is empty and no read is in flight, the block SHALL pulse done, drop busy the same cycle, and return to IDLE.
REQ-023 Every RAM word returned SHALL be pushed into the skid buffer the cycle it arrives; the buffer SHALL never overflow, given REQ-021.
REQ-024 out_valid SHALL equal buffer not empty; out_data SHALL be the buffer head, held stable while out_valid is high and out_ready is low.
REQ-025 Best-case latency: start at cycle T SHALL give the first ram_rd_en at T+1 and the first out_valid at T+3.
REQ-026 With out_ready held high, the block SHALL sustain one transfer per cycle.
REQ-027 start while busy SHALL be ignored, with no effect on pointer, remaining, or output.
REQ-028 len = 2048 SHALL read every location exactly once, ending at address wr_addr mod 2048.
REQ-029 len values above 2048 SHALL be clamped to 2048.
REQ-030 Writer activity during a readout is not arbitrated; external logic SHALL use busy to gate writes.
REQ-031 ram_rd_addr SHALL hold its last value when ram_rd_en is low.

Reset
REQ-032 Assertion of reset_n low SHALL immediately force the following values:
- FSM state: IDLE
- pointer: 0x7FF
- remaining: 0
- buffer: empty; in-flight flag: 0
- ram_rd_en, out_valid, busy, done: 0
- ram_rd_addr: 0x7FF
- out_data: 0
REQ-033 Reset mid-readout SHALL abandon the readout with no done pulse; data returning after deassertion SHALL be discarded.

Structure
REQ-034 ram_pkg SHALL hold ADDR_W = 11, RAM_DEPTH = 2048, START_ADDR = 11'h7FF, and the FSM state enum; the existing write addresser SHALL share it.
REQ-035 The skid buffer SHALL be a separate sub-module, rd_skid_fifo, a synchronous FIFO of SKID_DEPTH entries with push, pop, empty, full and count.

Verification
REQ-036 wr_addr = 0x7FC, len = 3, out_ready = 1 -> reads at 0x7FD, 0x7FE, 0x7FF; three transfers; done 1 cycle after the last transfer.
REQ-037 wr_addr = 0x7FE, len = 4 -> reads at 0x7FF, 0x000, 0x001, 0x002, confirming the wrap.
REQ-038 len = 5 with out_ready low for 10 cycles after the first out_valid -> at most SKID_DEPTH reads issued; out_data stable; all 5 words delivered in order once out_ready rises.
REQ-039 len = 0 -> done pulses at T+1; ram_rd_en never asserts; busy stays 0.
REQ-040 start again mid-readout (len = 8) -> ignored, exactly 8 transfers occur; reset_n pulsed low after 4 transfers -> all outputs reach reset values and no done pulse.
REQ-041 len = 2048, wr_addr = 0x000 -> 2048 transfers from address 0x001 through 0x000; the bench checks each address exactly once.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared RAM geometry and reader FSM encoding for the write addresser and ram_reader.
package ram_pkg;

    localparam int ADDR_W    = 11;
    localparam int LEN_W     = 12;
    localparam int RAM_DEPTH = 2048;
    localparam logic [ADDR_W-1:0] START_ADDR = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    // Requests longer than the RAM collapse to one full sweep.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(RAM_DEPTH)) ? LEN_W'(RAM_DEPTH) : len;
    endfunction

endpackage

// File: rtl/ram_reader_if.sv
// Control, RAM read port and output stream of ram_reader.
// master = the reader itself, slave = the surrounding logic (RAM + consumer).
interface ram_reader_if #(
    parameter int DATA_W = 8
);
    import ram_pkg::*;

    logic              start;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] wr_addr;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, len, wr_addr, ram_rd_data, out_ready,
        output ram_rd_en, ram_rd_addr, out_data, out_valid, busy, done
    );

    modport slave (
        output start, len, wr_addr, ram_rd_data, out_ready,
        input  ram_rd_en, ram_rd_addr, out_data, out_valid, busy, done
    );

endinterface

// File: rtl/rd_skid_fifo.sv
// Small synchronous FIFO catching RAM read data in front of the consumer.
module rd_skid_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Next storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // FIFO state register; storage clears so the head reads zero out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ram_reader.sv
// Newest-first readout of the downward-filled capture RAM into a ready/valid stream.
module ram_reader
    import ram_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int SKID_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    ram_reader_if.master bus
);

    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              inflight_q, inflight_d;
    logic              zero_done_q, zero_done_d;

    logic              rd_en;
    logic              drain_done;
    logic              pop;
    int                occupancy;

    logic [DATA_W-1:0] fifo_data;
    logic              fifo_empty;
    logic              fifo_full_unused;
    logic [CNT_W-1:0]  fifo_count;

    rd_skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight_q),
        .push_data (bus.ram_rd_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .full      (fifo_full_unused),
        .count     (fifo_count)
    );

    assign pop           = !fifo_empty && bus.out_ready;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_data;
    assign bus.ram_rd_en = rd_en;
    assign bus.ram_rd_addr = rd_en ? ptr_q : rd_addr_q;
    assign bus.done      = zero_done_q | drain_done;
    assign bus.busy      = (state_q != IDLE) && !drain_done;

    // Next-state, read issue and pointer/length bookkeeping.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        rd_addr_d   = rd_addr_q;
        zero_done_d = 1'b0;
        rd_en       = 1'b0;
        drain_done  = 1'b0;
        // A word leaving this cycle frees its slot, so credit the pop;
        // without it back-to-back transfers would stall every other cycle.
        occupancy   = int'(fifo_count) + int'(inflight_q) - int'(pop);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        state_d = READ;
                        ptr_d   = bus.wr_addr + ADDR_W'(1);
                        rem_d   = clamp_len(bus.len);
                    end
                end
            end
            READ: begin
                if ((rem_q != '0) && (occupancy < SKID_DEPTH)) begin
                    rd_en     = 1'b1;
                    rd_addr_d = ptr_q;
                    ptr_d     = ptr_q + ADDR_W'(1);
                    rem_d     = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty && !inflight_q) begin
                    drain_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        inflight_d = rd_en;
    end

    // Controller state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= START_ADDR;
            rd_addr_q   <= START_ADDR;
            rem_q       <= '0;
            inflight_q  <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rd_addr_q   <= rd_addr_d;
            rem_q       <= rem_d;
            inflight_q  <= inflight_d;
            zero_done_q <= zero_done_d;
        end
    end

endmodule

// File: tb/tb_ram_reader.sv
// Scoreboard bench for ram_reader: RAM model, random readouts, directed corner cases.
module tb_ram_reader;
    import ram_pkg::*;

    localparam int DW = 8;
    localparam int SD = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    ram_reader_if #(.DATA_W(DW)) bus ();

    ram_reader #(
        .DATA_W     (DW),
        .SKID_DEPTH (SD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    // RAM contents and a one-cycle-latency read port; garbage when not strobed.
    logic [DW-1:0] mem [RAM_DEPTH];
    always @(posedge clk)
        bus.ram_rd_data <= bus.ram_rd_en ? mem[bus.ram_rd_addr] : DW'($urandom);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer: 0 = always ready, 1 = random, 2 = held low.
    int ready_mode = 0;
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard queues filled at start, drained by the monitor.
    logic [ADDR_W-1:0] exp_addr [$];
    logic [DW-1:0]     exp_data [$];
    int  reads_total = 0;
    int  xfers_total = 0;
    int  done_count  = 0;
    int  last_xfer_cyc = 0;
    bit  track_visit = 1'b0;
    bit  visited [RAM_DEPTH];
    bit  prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_addr.delete();
            exp_data.delete();
            reads_total = 0;
            xfers_total = 0;
            prev_stall  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'(bus.out_data), 32'(prev_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                xfers_total++;
                last_xfer_cyc = cyc;
                check("xfer_expected", 32'(exp_data.size() != 0), 32'd1);
                if (exp_data.size() != 0)
                    check("out_data", 32'(bus.out_data), 32'(exp_data.pop_front()));
            end
            if (bus.ram_rd_en) begin
                reads_total++;
                check("read_expected", 32'(exp_addr.size() != 0), 32'd1);
                if (exp_addr.size() != 0)
                    check("rd_addr", 32'(bus.ram_rd_addr), 32'(exp_addr.pop_front()));
                if (track_visit) begin
                    check("visit_once", 32'(visited[bus.ram_rd_addr]), 32'd0);
                    visited[bus.ram_rd_addr] = 1'b1;
                end
                check("buffer_bound", 32'((reads_total - xfers_total) <= SD), 32'd1);
            end
            if (bus.done) done_count++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_rd_en"},   32'(bus.ram_rd_en),   32'd0);
        check({tag, "_rd_addr"}, 32'(bus.ram_rd_addr), 32'h7FF);
        check({tag, "_valid"},   32'(bus.out_valid),   32'd0);
        check({tag, "_data"},    32'(bus.out_data),    32'd0);
        check({tag, "_busy"},    32'(bus.busy),        32'd0);
        check({tag, "_done"},    32'(bus.done),        32'd0);
    endtask

    // Load expectations, pulse start for one cycle, check the first cycles.
    task automatic issue_start(input logic [ADDR_W-1:0] wr, input int len, input bit lat);
        int n;
        logic [ADDR_W-1:0] a;
        n = (len > RAM_DEPTH) ? RAM_DEPTH : len;
        for (int i = 0; i < n; i++) begin
            a = ADDR_W'((int'(wr) + 1 + i) % RAM_DEPTH);
            exp_addr.push_back(a);
            exp_data.push_back(mem[a]);
        end
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.len     = LEN_W'(len);
        bus.wr_addr = wr;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.len     = LEN_W'($urandom);
        bus.wr_addr = ADDR_W'($urandom);
        @(negedge clk);
        if (n == 0) begin
            check("zero_done_T+1", 32'(bus.done), 32'd1);
            check("zero_busy", 32'(bus.busy), 32'd0);
            check("zero_rd_en", 32'(bus.ram_rd_en), 32'd0);
        end else begin
            check("busy_after_start", 32'(bus.busy), 32'd1);
            if (lat) begin
                check("rd_en_T+1", 32'(bus.ram_rd_en), 32'd1);
                @(negedge clk);
                check("valid_T+2", 32'(bus.out_valid), 32'd0);
                @(negedge clk);
                check("valid_T+3", 32'(bus.out_valid), 32'd1);
            end
        end
    endtask

    // Bounded wait for done; optionally fire starts that must be ignored.
    task automatic wait_done(input int n, input bit poke);
        int budget;
        bit seen;
        budget = 8 * n + 64;
        seen   = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (poke && ($urandom_range(0, 7) == 0)) begin
                bus.start   = 1'b1;
                bus.len     = LEN_W'($urandom_range(1, 100));
                bus.wr_addr = ADDR_W'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                check("done_after_last_xfer", 32'(cyc), 32'(last_xfer_cyc + 1));
                check("busy_low_at_done", 32'(bus.busy), 32'd0);
                check("queues_drained", 32'(exp_data.size() + exp_addr.size()), 32'd0);
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("done_single_pulse", 32'(bus.done), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, x0, d0, lenv, vcount;
        logic [ADDR_W-1:0] wr;
        bit reached;

        bus.start   = 1'b0;
        bus.len     = '0;
        bus.wr_addr = '0;
        foreach (mem[i]) mem[i] = DW'($urandom);

        #1 reset_n = 1'b0;
        #1 check_reset_vals("reset");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Three entries ending exactly at the top of the RAM.
        ready_mode = 0;
        x0 = xfers_total;
        issue_start(11'h7FC, 3, 1'b1);
        wait_done(3, 1'b0);
        check("len3_xfers", 32'(xfers_total - x0), 32'd3);

        // Pointer wraps 0x7FF -> 0x000.
        x0 = xfers_total;
        issue_start(11'h7FE, 4, 1'b1);
        wait_done(4, 1'b0);
        check("wrap_xfers", 32'(xfers_total - x0), 32'd4);

        // Zero-length request.
        r0 = reads_total;
        issue_start(11'h055, 0, 1'b0);
        repeat (4) @(negedge clk);
        check("zero_no_reads", 32'(reads_total - r0), 32'd0);
        check("zero_busy_after", 32'(bus.busy), 32'd0);

        // Back-pressure: consumer stalls 10 cycles after first valid.
        ready_mode = 2;
        r0 = reads_total;
        x0 = xfers_total;
        issue_start(11'h123, 5, 1'b1);
        repeat (9) @(negedge clk);
        check("stall_reads_bounded", 32'((reads_total - r0) <= SD), 32'd1);
        check("stall_no_xfer", 32'(xfers_total - x0), 32'd0);
        ready_mode = 0;
        wait_done(5, 1'b0);
        check("stall_all_delivered", 32'(xfers_total - x0), 32'd5);

        // Start while busy is ignored.
        x0 = xfers_total;
        issue_start(11'h400, 8, 1'b0);
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.len     = 12'd20;
        bus.wr_addr = 11'h010;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        wait_done(8, 1'b0);
        check("busy_start_ignored", 32'(xfers_total - x0), 32'd8);

        // Reset in the middle of a readout.
        x0 = xfers_total;
        issue_start(11'h200, 8, 1'b0);
        reached = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if ((xfers_total - x0) >= 4) begin
                reached = 1'b1;
                break;
            end
        end
        check("reached_4_xfers", 32'(reached), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1 check_reset_vals("midreset");
        d0 = done_count;
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_done_after_reset", 32'(done_count), 32'(d0));
        check("idle_valid_after_reset", 32'(bus.out_valid), 32'd0);
        check("idle_busy_after_reset", 32'(bus.busy), 32'd0);

        // Random readouts with random back-pressure and ignored starts.
        for (int t = 0; t < 25; t++) begin
            ready_mode = $urandom_range(0, 1);
            wr = ADDR_W'($urandom);
            lenv = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
            x0 = xfers_total;
            issue_start(wr, lenv, 1'b0);
            if (lenv != 0) begin
                wait_done(lenv, 1'b1);
                check("rand_xfers", 32'(xfers_total - x0), 32'(lenv));
            end else begin
                repeat (2) @(negedge clk);
            end
        end

        // Oversized request is clamped to one full sweep.
        ready_mode = 0;
        x0 = xfers_total;
        issue_start(ADDR_W'($urandom), 3000, 1'b0);
        wait_done(RAM_DEPTH, 1'b1);
        check("clamp_xfers", 32'(xfers_total - x0), 32'd2048);

        // Full sweep from wr_addr 0: every address once, ending at 0x000.
        foreach (visited[i]) visited[i] = 1'b0;
        track_visit = 1'b1;
        x0 = xfers_total;
        issue_start(11'h000, 2048, 1'b1);
        wait_done(RAM_DEPTH, 1'b0);
        track_visit = 1'b0;
        vcount = 0;
        foreach (visited[i]) vcount += int'(visited[i]);
        check("full_sweep_coverage", 32'(vcount), 32'd2048);
        check("full_sweep_xfers", 32'(xfers_total - x0), 32'd2048);
        check("full_sweep_last_addr", 32'(bus.ram_rd_addr), 32'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
